// File: rtl/perf_snapshot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_pkg
// Description : Shared types, address map constants and helpers for the
//               performance-counter snapshot master.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_snapshot_pkg;

    // Snapshot sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_HDR    = 3'd2,
        ST_ADDR   = 3'd3,
        ST_DATA   = 3'd4,
        ST_RESUME = 3'd5
    } state_t;

    // Counter slave address map: each section occupies four words
    localparam int unsigned SECTION_STRIDE = 4;
    localparam logic [1:0]  OFF_TIME_LO    = 2'd0;
    localparam logic [1:0]  OFF_TIME_HI    = 2'd1;
    localparam logic [1:0]  OFF_EVENT      = 2'd2;

    // Section-0 control words: writing address 0 stops, address 1 restarts
    localparam logic [4:0]  ADDR_STOP0     = 5'd0;
    localparam logic [4:0]  ADDR_GO0       = 5'd1;

    // Word address of a given section/offset pair
    function automatic logic [4:0] word_addr(input logic [2:0] sec, input logic [1:0] off);
        return 5'(32'(sec) * SECTION_STRIDE) + {3'b000, off};
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_snapshot_timer.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_timer
// Description : Sample-period down-counter. Emits a one-cycle tick every
//               SAMPLE_PERIOD enabled cycles; SAMPLE_PERIOD = 0 never ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_snapshot_timer #(
    parameter int unsigned SAMPLE_PERIOD = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    // For a zero period the reload wraps to all ones; the tick is gated off below
    localparam logic [31:0] RELOAD = 32'(SAMPLE_PERIOD - 1);

    logic [31:0] r_count;

    // Count down while enabled, reload on zero; park at the reload value when disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RELOAD;
        end else if (!enable) begin
            r_count <= RELOAD;
        end else if (r_count == 32'd0) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - 32'd1;
        end
    end

    assign tick = (SAMPLE_PERIOD != 0) && enable && (r_count == 32'd0);

endmodule
`default_nettype wire

// File: rtl/perf_snapshot_master.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_master
// Description : Avalon-MM master that freezes the performance counter slave,
//               reads time-lo/time-hi/event words of each section, streams
//               them as one packet headed by a sequence number, then restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_snapshot_master
    import perf_snapshot_pkg::*;
#(
    parameter int unsigned NUM_SECTIONS  = 8,
    parameter int unsigned SAMPLE_PERIOD = 50000000,
    parameter bit          FREEZE        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trigger,
    output logic [4:0]  pc_address,
    output logic        pc_write,
    output logic        pc_begintransfer,
    output logic [31:0] pc_writedata,
    input  logic [31:0] pc_readdata,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [31:0] sample_data,
    output logic        sample_sop,
    output logic        sample_eop,
    output logic        busy,
    output logic [15:0] overrun_count
);

    localparam logic [2:0] LAST_SEC = 3'(NUM_SECTIONS - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_pending;
    logic [15:0] r_overrun;
    logic [31:0] r_seq;
    logic [2:0]  r_sec;
    logic [1:0]  r_off;
    logic [31:0] r_data;
    logic        r_captured;

    logic        w_tick;
    logic        w_req;
    logic        w_busy;
    logic        w_start;
    logic        w_last;
    logic [4:0]  w_addr;

    perf_snapshot_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (w_tick)
    );

    assign w_req         = trigger | w_tick;
    assign w_busy        = (r_state != ST_IDLE);
    // A request in IDLE starts immediately, without waiting a cycle for pending
    assign w_start       = (r_state == ST_IDLE) && (r_pending || w_req);
    assign w_last        = (r_sec == LAST_SEC) && (r_off == OFF_EVENT);
    assign w_addr        = word_addr(r_sec, r_off);
    assign busy          = w_busy;
    assign overrun_count = r_overrun;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: header, then an ADDR/DATA pair per word, then resume
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_FREEZE;
            ST_FREEZE: w_next = ST_HDR;
            ST_HDR:    if (sample_ready) w_next = ST_ADDR;
            ST_ADDR:   w_next = ST_DATA;
            ST_DATA:   if (sample_ready) w_next = w_last ? ST_RESUME : ST_ADDR;
            ST_RESUME: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output decode; the counter write strobe exists only in FREEZE/RESUME
    always_comb begin
        pc_address       = 5'd0;
        pc_write         = 1'b0;
        pc_begintransfer = 1'b0;
        pc_writedata     = 32'd0;
        sample_valid     = 1'b0;
        sample_data      = 32'd0;
        sample_sop       = 1'b0;
        sample_eop       = 1'b0;
        case (r_state)
            ST_FREEZE: begin
                pc_address       = ADDR_STOP0;
                pc_write         = FREEZE;
                pc_begintransfer = FREEZE;
            end
            ST_HDR: begin
                sample_valid = 1'b1;
                sample_sop   = 1'b1;
                sample_data  = r_seq;
            end
            ST_ADDR: begin
                pc_address = w_addr;
            end
            ST_DATA: begin
                pc_address   = w_addr;
                sample_valid = 1'b1;
                // First DATA cycle forwards the slave word; later stall cycles replay the copy
                sample_data  = r_captured ? r_data : pc_readdata;
                sample_eop   = w_last;
            end
            ST_RESUME: begin
                pc_address       = ADDR_GO0;
                pc_write         = FREEZE;
                pc_begintransfer = FREEZE;
            end
            default: ;
        endcase
    end

    // Request bookkeeping: coalesce into one pending flag, count the surplus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 16'd0;
        end else begin
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end
            if (w_req && (w_busy || r_pending) && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end
        end
    end

    // Word pointer, read-data hold register and packet sequence number
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq      <= 32'd0;
            r_sec      <= 3'd0;
            r_off      <= OFF_TIME_LO;
            r_data     <= 32'd0;
            r_captured <= 1'b0;
        end else begin
            case (r_state)
                ST_HDR: begin
                    r_sec <= 3'd0;
                    r_off <= OFF_TIME_LO;
                end
                ST_ADDR: begin
                    r_captured <= 1'b0;
                end
                ST_DATA: begin
                    if (!r_captured) begin
                        r_data     <= pc_readdata;
                        r_captured <= 1'b1;
                    end
                    if (sample_ready) begin
                        if (r_off == OFF_EVENT) begin
                            r_off <= OFF_TIME_LO;
                            r_sec <= r_sec + 3'd1;
                        end else begin
                            r_off <= r_off + 2'd1;
                        end
                    end
                end
                ST_RESUME: begin
                    r_seq <= r_seq + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_snapshot_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_snapshot_master
// Description : Scoreboard bench for perf_snapshot_master. Four instances
//               cover the main 2-section freeze build, two timer builds and
//               a no-freeze build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_snapshot_master;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct {
        int addr;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic zero = 1'b0;
    logic one = 1'b1;
    logic trig_a = 1'b0;
    logic trig_d = 1'b0;
    logic ready_a = 1'b1;
    logic bc_en = 1'b0;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail = 0;
    bit ign = 1'b0;

    word_t qa[$];
    word_t qd[$];
    wr_t   wa[$];
    int    b_st[$];

    // DUT A: 2 sections, no timer, freeze on
    logic [4:0]  a_addr;  logic a_wr, a_bt, a_valid, a_sop, a_eop, a_busy;
    logic [31:0] a_wd, a_rd, a_data;  logic [15:0] a_ovr;
    // DUT B: 1 section, period 20
    logic [4:0]  b_addr;  logic b_wr, b_bt, b_valid, b_sop, b_eop, b_busy;
    logic [31:0] b_wd, b_rd, b_data;  logic [15:0] b_ovr;
    // DUT C: 1 section, period 5
    logic [4:0]  c_addr;  logic c_wr, c_bt, c_valid, c_sop, c_eop, c_busy;
    logic [31:0] c_wd, c_rd, c_data;  logic [15:0] c_ovr;
    // DUT D: 2 sections, no timer, freeze off
    logic [4:0]  d_addr;  logic d_wr, d_bt, d_valid, d_sop, d_eop, d_busy;
    logic [31:0] d_wd, d_rd, d_data;  logic [15:0] d_ovr;

    perf_snapshot_master #(.NUM_SECTIONS(2), .SAMPLE_PERIOD(0), .FREEZE(1'b1)) u_a (
        .clk(clk), .reset(reset), .enable(zero), .trigger(trig_a),
        .pc_address(a_addr), .pc_write(a_wr), .pc_begintransfer(a_bt), .pc_writedata(a_wd),
        .pc_readdata(a_rd), .sample_valid(a_valid), .sample_ready(ready_a), .sample_data(a_data),
        .sample_sop(a_sop), .sample_eop(a_eop), .busy(a_busy), .overrun_count(a_ovr));

    perf_snapshot_master #(.NUM_SECTIONS(1), .SAMPLE_PERIOD(20), .FREEZE(1'b1)) u_b (
        .clk(clk), .reset(reset), .enable(bc_en), .trigger(zero),
        .pc_address(b_addr), .pc_write(b_wr), .pc_begintransfer(b_bt), .pc_writedata(b_wd),
        .pc_readdata(b_rd), .sample_valid(b_valid), .sample_ready(one), .sample_data(b_data),
        .sample_sop(b_sop), .sample_eop(b_eop), .busy(b_busy), .overrun_count(b_ovr));

    perf_snapshot_master #(.NUM_SECTIONS(1), .SAMPLE_PERIOD(5), .FREEZE(1'b1)) u_c (
        .clk(clk), .reset(reset), .enable(bc_en), .trigger(zero),
        .pc_address(c_addr), .pc_write(c_wr), .pc_begintransfer(c_bt), .pc_writedata(c_wd),
        .pc_readdata(c_rd), .sample_valid(c_valid), .sample_ready(one), .sample_data(c_data),
        .sample_sop(c_sop), .sample_eop(c_eop), .busy(c_busy), .overrun_count(c_ovr));

    perf_snapshot_master #(.NUM_SECTIONS(2), .SAMPLE_PERIOD(0), .FREEZE(1'b0)) u_d (
        .clk(clk), .reset(reset), .enable(zero), .trigger(trig_d),
        .pc_address(d_addr), .pc_write(d_wr), .pc_begintransfer(d_bt), .pc_writedata(d_wd),
        .pc_readdata(d_rd), .sample_valid(d_valid), .sample_ready(one), .sample_data(d_data),
        .sample_sop(d_sop), .sample_eop(d_eop), .busy(d_busy), .overrun_count(d_ovr));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter slave stand-in: distinct constant per address, registered read
    function automatic logic [31:0] mem_val(input logic [4:0] a);
        return 32'h5A00_0011 + 32'(a) * 32'h0001_0101;
    endfunction

    always @(posedge clk) begin
        a_rd <= mem_val(a_addr);
        b_rd <= mem_val(b_addr);
        c_rd <= mem_val(c_addr);
        d_rd <= mem_val(d_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected 2-section packet: seq, then addresses 0,1,2,4,5,6
    task automatic push_pkt(input bit to_d, input logic [31:0] seq);
        word_t w;
        w = '{data: seq, sop: 1'b1, eop: 1'b0};
        if (to_d) qd.push_back(w); else qa.push_back(w);
        for (int s = 0; s < 2; s++) begin
            for (int o = 0; o < 3; o++) begin
                w = '{data: mem_val(5'(4 * s + o)), sop: 1'b0, eop: (s == 1 && o == 2)};
                if (to_d) qd.push_back(w); else qa.push_back(w);
            end
        end
    endtask

    task automatic wait_done(input bit is_d, input int n, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < n && !done; k++) begin
            @(negedge clk);
            if (is_d) done = !d_busy && (qd.size() == 0);
            else      done = !a_busy && (qa.size() == 0) && (wa.size() == 0);
        end
        chk({name, "_completed"}, 32'(done), 32'd1);
    endtask

    // Monitor A: packet words, write strobes and stall stability
    bit          p_stall = 1'b0;
    logic [31:0] p_data;
    logic        p_sop, p_eop;
    logic [4:0]  p_addr;
    always @(negedge clk) begin
        word_t w;
        wr_t   e;
        if (reset || ign) begin
            p_stall = 1'b0;
        end else begin
            if (a_wr || a_bt) begin
                chk("a_bt_with_wr", 32'(a_bt), 32'(a_wr));
                if (wa.size() == 0) chk("a_unexpected_write", 32'(wa.size()), 32'd1);
                else begin
                    e = wa.pop_front();
                    chk("a_wr_addr", 32'(a_addr), 32'(e.addr));
                    chk("a_wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (p_stall) begin
                chk("a_stall_valid", 32'(a_valid), 32'd1);
                chk("a_stall_data", a_data, p_data);
                chk("a_stall_flags", {30'd0, a_sop, a_eop}, {30'd0, p_sop, p_eop});
                chk("a_stall_addr", 32'(a_addr), 32'(p_addr));
            end
            if (a_valid && ready_a) begin
                if (qa.size() == 0) chk("a_unexpected_word", 32'(qa.size()), 32'd1);
                else begin
                    w = qa.pop_front();
                    chk("a_word_data", a_data, w.data);
                    chk("a_word_flags", {30'd0, a_sop, a_eop}, {30'd0, w.sop, w.eop});
                end
            end
            p_stall = a_valid && !ready_a;
            p_data = a_data; p_sop = a_sop; p_eop = a_eop; p_addr = a_addr;
        end
    end

    // Monitor D: packet words, and no counter write is ever issued
    int d_wr_cnt = 0;
    always @(negedge clk) begin
        word_t w;
        if (!reset) begin
            if (d_wr || d_bt) d_wr_cnt++;
            if (d_valid) begin
                if (qd.size() == 0) chk("d_unexpected_word", 32'(qd.size()), 32'd1);
                else begin
                    w = qd.pop_front();
                    chk("d_word_data", d_data, w.data);
                    chk("d_word_flags", {30'd0, d_sop, d_eop}, {30'd0, w.sop, w.eop});
                end
            end
        end
    end

    // Monitors B/C: snapshot start cycles, header sequence, packet/write counts
    bit          b_prev = 1'b0;
    logic [31:0] b_seq_exp = 0, c_seq_exp = 0;
    int          b_eops = 0, b_wrs = 0, c_sops = 0, c_eops = 0, c_wrs = 0;
    logic [31:0] wd_or = 32'd0;
    always @(negedge clk) begin
        wd_or = wd_or | a_wd | b_wd | c_wd | d_wd;
        if (!reset) begin
            if (b_busy && !b_prev) b_st.push_back(cyc);
            b_prev = b_busy;
            if (b_valid && b_sop) begin
                chk("b_hdr_seq", b_data, b_seq_exp);
                b_seq_exp++;
            end
            if (b_valid && b_eop) b_eops++;
            if (b_wr && b_bt) b_wrs++;
            if (c_valid && c_sop) begin
                chk("c_hdr_seq", c_data, c_seq_exp);
                c_seq_exp++;
                c_sops++;
            end
            if (c_valid && c_eop) c_eops++;
            if (c_wr && c_bt) c_wrs++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int e0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_write", 32'(a_wr | a_bt), 32'd0);
        chk("rst_addr",  32'(a_addr), 32'd0);
        chk("rst_data",  a_data, 32'd0);
        chk("rst_flags", 32'(a_sop | a_eop), 32'd0);
        chk("rst_busy",  32'(a_busy), 32'd0);
        chk("rst_ovr",   32'(a_ovr), 32'd0);

        // Basic 7-word packet, stop write at T+1, go write at T+15
        @(posedge clk); #1;
        t0 = cyc; trig_a = 1'b1;
        push_pkt(1'b0, 32'd0);
        wa.push_back('{0, t0 + 1}); wa.push_back('{1, t0 + 15});
        @(posedge clk); #1 trig_a = 1'b0;
        wait_done(1'b0, 100, "basic");

        // Five-cycle stall on word 3 stretches the snapshot to 20 cycles
        @(posedge clk); #1;
        t0 = cyc; trig_a = 1'b1;
        push_pkt(1'b0, 32'd1);
        wa.push_back('{0, t0 + 1}); wa.push_back('{1, t0 + 20});
        @(posedge clk); #1 trig_a = 1'b0;
        repeat (7) @(posedge clk);
        #1 ready_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_a = 1'b1;
        wait_done(1'b0, 100, "stall");

        // Reset while in DATA truncates the packet
        @(posedge clk); #1;
        ign = 1'b1; t0 = cyc; trig_a = 1'b1;
        @(posedge clk); #1 trig_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_in_data", 32'(a_valid & a_busy), 32'd1);
        @(negedge clk);
        chk("midrst_valid", 32'(a_valid), 32'd0);
        chk("midrst_write", 32'(a_wr), 32'd0);
        chk("midrst_busy",  32'(a_busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; ign = 1'b0; qa.delete(); wa.delete();

        // Two requests during a snapshot coalesce into one follow-up (seq 1)
        @(posedge clk); #1;
        t0 = cyc; trig_a = 1'b1;
        push_pkt(1'b0, 32'd0);
        push_pkt(1'b0, 32'd1);
        wa.push_back('{0, t0 + 1});  wa.push_back('{1, t0 + 15});
        wa.push_back('{0, t0 + 17}); wa.push_back('{1, t0 + 31});
        @(posedge clk); #1 trig_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 trig_a = 1'b1;
        @(posedge clk); #1 trig_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 trig_a = 1'b1;
        @(posedge clk); #1 trig_a = 1'b0;
        wait_done(1'b0, 200, "coalesce");
        chk("coalesce_ovr", 32'(a_ovr), 32'd2);
        repeat (30) @(negedge clk);
        chk("coalesce_quiet", 32'(a_busy), 32'd0);

        // FREEZE=0: packets still produced, counter never written
        @(posedge clk); #1 trig_d = 1'b1;
        push_pkt(1'b1, 32'd0);
        @(posedge clk); #1 trig_d = 1'b0;
        wait_done(1'b1, 100, "nofreeze0");
        @(posedge clk); #1 trig_d = 1'b1;
        push_pkt(1'b1, 32'd1);
        @(posedge clk); #1 trig_d = 1'b0;
        wait_done(1'b1, 100, "nofreeze1");
        chk("d_no_write", 32'(d_wr_cnt), 32'd0);

        // Timer builds: period 20 without overruns, period 5 overruns every tick
        @(posedge clk); #1;
        bc_en = 1'b1; e0 = cyc;
        @(negedge clk);
        while (cyc < e0 + 25) @(negedge clk);
        chk("c_ovr_25", 32'(c_ovr), 32'd4);
        while (cyc < e0 + 30) @(negedge clk);
        chk("c_ovr_30", 32'(c_ovr), 32'd5);
        while (cyc < e0 + 50) @(negedge clk);
        chk("c_ovr_50", 32'(c_ovr), 32'd9);
        while (cyc < e0 + 90) @(negedge clk);
        chk("b_start_count", 32'(b_st.size()), 32'd4);
        if (b_st.size() > 0) chk("b_first_start", 32'(b_st[0]), 32'(e0 + 20));
        for (int i = 1; i < b_st.size(); i++) chk("b_period", 32'(b_st[i] - b_st[i-1]), 32'd20);
        chk("b_ovr", 32'(b_ovr), 32'd0);
        @(posedge clk); #1 bc_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("c_idle", 32'(c_busy), 32'd0);
        chk("b_writes", 32'(b_wrs), 32'(2 * b_eops));
        chk("c_packets", 32'(c_eops), 32'(c_sops));
        chk("c_writes", 32'(c_wrs), 32'(2 * c_eops));
        chk("writedata_zero", wd_or, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_snapshot_master.md
# perf_snapshot_master

Avalon-MM master that sits directly upstream of the 8-section performance counter slave and drives its control port. It takes periodic or triggered coherent snapshots: it freezes all counters via a section-0 stop write, then reads time-lo, time-hi and event words for each section. It emits them as one packet on a streaming output toward the logging DMA/FIFO, then restarts section 0 with a go write.

## Interface
- NUM_SECTIONS, 8, sections read per snapshot (1..8).
- SAMPLE_PERIOD, 50000000, cycles between timer-triggered snapshots; 0 disables the timer.
- FREEZE, 1, 1 = bracket reads with stop/go writes to section 0; 0 = no counter writes.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  timer run enable.
- trigger  in  1  single-cycle manual snapshot request.
- pc_address  out  5  counter slave word address.
- pc_write  out  1  counter slave write.
- pc_begintransfer  out  1  asserted only with pc_write.
- pc_writedata  out  32  always 0.
- pc_readdata  in  32  registered slave read data, valid 1 cycle after pc_address.
- sample_valid / sample_ready  out / in  1  stream handshake.
- sample_data  out  32  packet word.
- sample_sop / sample_eop  out  1  first / last word of packet.
- busy  out  1  snapshot in progress (state != IDLE).
- overrun_count  out  16  requests that arrived while busy, saturating.

## Operation
- Packet order: word 0 is the 32-bit sequence number. For s = 0..NUM_SECTIONS-1 it is followed by words at addresses 4s (time lo), 4s+1 (time hi) and 4s+2 (event lo). Length is 3*NUM_SECTIONS+1.
- FSM states: IDLE, FREEZE, HDR, ADDR, DATA, RESUME.
- IDLE -> FREEZE when pending=1. Clear pending.
- FREEZE: one cycle with pc_address=0, pc_write=1, pc_begintransfer=1. This stops section 0 and therefore the global enable. If FREEZE=0, the cycle is spent with no write.
- HDR: sample_valid=1, sop=1, data=seq. Go to ADDR on ready.
- ADDR: drive the word address for one cycle.
- DATA: hold the address, sample_data=pc_readdata (latched on entry, stable while stalled), valid=1, eop on the last word. On ready, go to ADDR for the next word, or to RESUME after the last word.
- RESUME: one cycle with pc_address=1 and write strobe (go, section 0), skipped if FREEZE=0. Increment seq (wraps 0xFFFFFFFF->0). Go to IDLE.
- Section 0 is owned by this block when FREEZE=1. Each snapshot increments section 0's event counter by 1; software uses sections 1..7.
- pending is set by a trigger pulse or a timer tick. A request while busy or while pending is already set increments overrun_count (sticky at 0xFFFF). pending stays 1, so requests coalesce into one follow-up snapshot.
- Timer: a down-counter loads SAMPLE_PERIOD-1 and decrements while enable=1. At 0 it ticks and reloads. When enable=0 it holds at the reload value.
- enable falling mid-snapshot: the snapshot completes.

## Timing
- Reset values: all outputs 0, pc_address=0, seq=0, overrun_count=0, pending=0, state IDLE, timer reloaded.
- trigger at cycle T: FREEZE at T+1, HDR at T+2.
- With ready held high, a snapshot occupies 6*NUM_SECTIONS+3 cycles from FREEZE to RESUME inclusive (51 for 8 sections).
- pc_write is never asserted outside FREEZE/RESUME. A write lasts exactly one cycle.
- sample_valid, once high, stays high with stable data/sop/eop until ready.
- Reset mid-packet: outputs are 0 on the next cycle and the packet is truncated. The counter slave shares the reset and is cleared as well.

## Structure
- Shared package perf_snapshot_pkg: state enum; constants SECTION_STRIDE=4, OFF_TIME_LO=0, OFF_TIME_HI=1, OFF_EVENT=2, ADDR_STOP0=0, ADDR_GO0=1.
- Sub-module perf_snapshot_timer: period down-counter plus tick output.

## Test plan
- NUM_SECTIONS=2, slave model with distinct values, trigger, ready=1 -> 7-word packet (seq 0, then addresses 0,1,2,4,5,6), sop on word 0, eop on word 6. One write to addr 0 at T+1, one write to addr 1 at T+15.
- Hold ready low 5 cycles on word 3 -> data/address stable, no extra pc_write, total length 20 cycles.
- NUM_SECTIONS=1, SAMPLE_PERIOD=20, enable=1 -> snapshots start every 20 cycles, overrun_count stays 0. SAMPLE_PERIOD=5 -> overrun_count increments every period.
- Two triggers during one snapshot -> overrun_count=2, exactly one follow-up packet with seq=1.
- Reset in DATA -> next cycle valid=0, pc_write=0, seq=0. A following trigger yields a full packet with seq 0.
- FREEZE=0, trigger -> packet produced, pc_write never asserted.
